// File: rtl/ag32gbd_buffer_sequencer.sv
// ---------------------------------------------------------------------------
// ag32gbd_buffer_sequencer
//
// Ping-pong sequencer for the two camera image buffers held in the dual-port
// BRAM controller. The capture byte stream is written into the port-A buffer.
// The port-B buffer is drained to a valid/ready consumer. The two buffers are
// swapped (FlipBuffer) only when the write buffer is full and the read buffer
// has been completely drained.
//
// Ports
//   sys_clock, resetn          clock (rising edge), async active-low reset
//   in_valid/in_data/in_sof    capture byte stream; in_sof restarts offset 0
//   in_ready                   sequencer can accept a capture byte
//   RequestWriteBuffer         write request level, held until done
//   BufferWriteData/Offset     write byte and offset ([9:8] always 0)
//   BufferWriteDataDone        write-complete pulse from the controller
//   RequestReadBuffer          read request level, held until ready
//   BufferReadOffset           read offset ([9:8] always 0)
//   BufferReadOutput           read byte from the controller
//   BufferReadDataReady        read-complete pulse from the controller
//   out_valid/out_data/out_last, out_ready   drained byte stream
//   FlipBuffer                 buffer select to the controller
//   flip_pulse                 one-cycle pulse on each flip
//   frame_count                number of flips, wraps modulo 256
// ---------------------------------------------------------------------------
module ag32gbd_buffer_sequencer #(
    parameter int BUF_BYTES = 256
) (
    input  logic       sys_clock,
    input  logic       resetn,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    input  logic       in_sof,
    output logic       in_ready,
    output logic       RequestWriteBuffer,
    output logic [7:0] BufferWriteData,
    output logic [9:0] BufferWriteOffset,
    input  logic       BufferWriteDataDone,
    output logic       RequestReadBuffer,
    output logic [9:0] BufferReadOffset,
    input  logic [7:0] BufferReadOutput,
    input  logic       BufferReadDataReady,
    output logic       out_valid,
    output logic [7:0] out_data,
    output logic       out_last,
    input  logic       out_ready,
    output logic       FlipBuffer,
    output logic       flip_pulse,
    output logic [7:0] frame_count
);

    localparam logic [7:0] LAST_OFF = 8'(BUF_BYTES - 1);

    typedef enum logic [1:0] {W_FILL, W_REQ, W_FULL} wrState_t;
    typedef enum logic [1:0] {R_EMPTY, R_REQ, R_OUT} rdState_t;

    wrState_t   wrState, wrNext;
    rdState_t   rdState, rdNext;
    logic [7:0] wrOff;      // next sequential write offset
    logic [7:0] wrReqOff;   // offset of the write currently requested
    logic [7:0] rdOff;
    logic       accept;
    logic       doFlip;

    // in_ready is registered, so a byte is taken only once it is actually shown
    assign accept            = (wrState == W_FILL) && in_valid && in_ready;
    assign BufferWriteOffset = {2'b00, wrReqOff};
    assign BufferReadOffset  = {2'b00, rdOff};

    // Next states without the flip; the flip decision looks at where both
    // FSMs are about to land so a swap can happen on the completing edge.
    always_comb begin
        wrNext = wrState;
        rdNext = rdState;
        case (wrState)
            W_FILL:  if (accept) wrNext = W_REQ;
            W_REQ:   if (BufferWriteDataDone)
                         wrNext = (wrReqOff == LAST_OFF) ? W_FULL : W_FILL;
            default: ;
        endcase
        case (rdState)
            R_REQ:   if (BufferReadDataReady) rdNext = R_OUT;
            R_OUT:   if (out_ready) rdNext = out_last ? R_EMPTY : R_REQ;
            default: ;
        endcase
        doFlip = (wrNext == W_FULL) && (rdNext == R_EMPTY);
    end

    always_ff @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            wrState            <= W_FILL;
            rdState            <= R_EMPTY;
            wrOff              <= 8'd0;
            wrReqOff           <= 8'd0;
            rdOff              <= 8'd0;
            in_ready           <= 1'b0;
            RequestWriteBuffer <= 1'b0;
            BufferWriteData    <= 8'd0;
            RequestReadBuffer  <= 1'b0;
            out_valid          <= 1'b0;
            out_data           <= 8'd0;
            out_last           <= 1'b0;
            FlipBuffer         <= 1'b0;
            flip_pulse         <= 1'b0;
            frame_count        <= 8'd0;
        end else begin
            wrState    <= wrNext;
            rdState    <= rdNext;
            flip_pulse <= doFlip;

            // ---- writer ----
            case (wrState)
                W_FILL: begin
                    if (accept) begin
                        BufferWriteData    <= in_data;
                        wrReqOff           <= in_sof ? 8'd0 : wrOff;
                        RequestWriteBuffer <= 1'b1;
                        in_ready           <= 1'b0;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                W_REQ: begin
                    // Request, data and offset stay put until the controller
                    // finishes; it may defer us behind register traffic.
                    if (BufferWriteDataDone) begin
                        RequestWriteBuffer <= 1'b0;
                        wrOff              <= wrReqOff + 8'd1;
                        in_ready           <= (wrReqOff != LAST_OFF);
                    end
                end
                default: in_ready <= 1'b0;
            endcase

            // ---- reader ----
            case (rdState)
                R_REQ: begin
                    if (BufferReadDataReady) begin
                        out_data          <= BufferReadOutput;
                        out_valid         <= 1'b1;
                        out_last          <= (rdOff == LAST_OFF);
                        RequestReadBuffer <= 1'b0;
                    end
                end
                R_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (out_last) begin
                            rdOff <= 8'd0;
                        end else begin
                            rdOff             <= rdOff + 8'd1;
                            RequestReadBuffer <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase

            // ---- flip: overrides the transitions above ----
            if (doFlip) begin
                FlipBuffer        <= ~FlipBuffer;
                frame_count       <= frame_count + 8'd1;
                wrState           <= W_FILL;
                wrOff             <= 8'd0;
                in_ready          <= 1'b1;
                rdState           <= R_REQ;
                rdOff             <= 8'd0;
                RequestReadBuffer <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ag32gbd_buffer_sequencer.sv
`timescale 1ns/1ps
module tb_ag32gbd_buffer_sequencer;
    localparam int N = 256;

    logic       sys_clock = 1'b0;
    logic       resetn = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_data = 8'd0;
    logic       in_sof = 1'b0;
    logic       in_ready;
    logic       RequestWriteBuffer;
    logic [7:0] BufferWriteData;
    logic [9:0] BufferWriteOffset;
    logic       BufferWriteDataDone;
    logic       RequestReadBuffer;
    logic [9:0] BufferReadOffset;
    logic [7:0] BufferReadOutput;
    logic       BufferReadDataReady;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready = 1'b0;
    logic       FlipBuffer;
    logic       flip_pulse;
    logic [7:0] frame_count;

    always #5 sys_clock = ~sys_clock;

    ag32gbd_buffer_sequencer #(.BUF_BYTES(N)) dut (
        .sys_clock(sys_clock), .resetn(resetn),
        .in_valid(in_valid), .in_data(in_data), .in_sof(in_sof), .in_ready(in_ready),
        .RequestWriteBuffer(RequestWriteBuffer), .BufferWriteData(BufferWriteData),
        .BufferWriteOffset(BufferWriteOffset), .BufferWriteDataDone(BufferWriteDataDone),
        .RequestReadBuffer(RequestReadBuffer), .BufferReadOffset(BufferReadOffset),
        .BufferReadOutput(BufferReadOutput), .BufferReadDataReady(BufferReadDataReady),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .out_ready(out_ready),
        .FlipBuffer(FlipBuffer), .flip_pulse(flip_pulse), .frame_count(frame_count)
    );

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge sys_clock);
        #1;
    endtask

    int cyc = 0;
    always @(posedge sys_clock) cyc <= cyc + 1;

    // ---------------- BRAM controller model ----------------
    int  wrStall = 0;
    int  rdStall = 0;
    bit  randStall = 1'b0;
    int  wrCnt, rdCnt;
    logic [7:0] mem [0:1][0:N-1];

    always @(posedge sys_clock or negedge resetn) begin
        if (!resetn) begin
            BufferWriteDataDone <= 1'b0;
            BufferReadDataReady <= 1'b0;
            BufferReadOutput    <= 8'd0;
            wrCnt <= 0;
            rdCnt <= 0;
        end else begin
            if (RequestWriteBuffer && !BufferWriteDataDone) begin
                if (wrCnt >= 2 + wrStall && (!randStall || $urandom_range(0, 3) == 0)) begin
                    BufferWriteDataDone <= 1'b1;
                    mem[FlipBuffer][BufferWriteOffset[7:0]] <= BufferWriteData;
                end else wrCnt <= wrCnt + 1;
            end else begin
                BufferWriteDataDone <= 1'b0;
                wrCnt <= 0;
            end
            if (RequestReadBuffer && !BufferReadDataReady) begin
                if (rdCnt >= rdStall && (!randStall || $urandom_range(0, 2) == 0)) begin
                    BufferReadDataReady <= 1'b1;
                    BufferReadOutput <= mem[~FlipBuffer][BufferReadOffset[7:0]];
                end else rdCnt <= rdCnt + 1;
            end else begin
                BufferReadDataReady <= 1'b0;
                rdCnt <= 0;
            end
        end
    end

    // ---------------- reference model + monitors ----------------
    logic [7:0]  mFrame [0:N-1];
    int          mOff = 0;
    logic [15:0] expWrQ [$];   // {offset, data} per accepted byte
    logic [8:0]  expOutQ [$];  // {last, data} per byte of each completed frame
    int   hsCount = 0, lastCount = 0, flipCount = 0, lastHsCyc = 0, flipCyc = 0, protoErr = 0;
    logic [7:0] expFrameCount = 8'd0;
    logic expFlip = 1'b0;
    bit   wrStable = 1'b0;
    logic prevReq = 1'b0, prevOV = 1'b0, prevOR = 1'b0, prevPulse = 1'b0;
    logic [7:0] prevWD = 8'd0;
    logic [9:0] prevWO = 10'd0;

    always @(negedge sys_clock) begin : mon
        int off;
        logic [15:0] w;
        logic [8:0] e;
        if (!resetn) begin
            expWrQ.delete();
            expOutQ.delete();
            mOff = 0;
            expFrameCount = 8'd0;
            expFlip = 1'b0;
            prevReq = 1'b0;
            prevOV = 1'b0;
            prevPulse = 1'b0;
        end else begin
            if (in_valid && in_ready) begin
                off = in_sof ? 0 : mOff;
                mFrame[off] = in_data;
                expWrQ.push_back({off[7:0], in_data});
                mOff = off + 1;
                if (off == N - 1) begin
                    for (int i = 0; i < N; i++) expOutQ.push_back({(i == N - 1), mFrame[i]});
                    mOff = 0;
                end
            end
            if (RequestWriteBuffer) begin
                if (!prevReq) wrStable = 1'b1;
                else if (BufferWriteData !== prevWD || BufferWriteOffset !== prevWO) wrStable = 1'b0;
                if (in_ready) wrStable = 1'b0;
                if (BufferWriteDataDone) begin
                    chk("wr_stable", wrStable, 1);
                    chk("wr_pending", expWrQ.size() != 0, 1);
                    if (expWrQ.size() != 0) begin
                        w = expWrQ.pop_front();
                        chk("wr_off", BufferWriteOffset, {2'b00, w[15:8]});
                        chk("wr_data", BufferWriteData, w[7:0]);
                    end
                end
            end
            if (out_valid && out_ready) begin
                hsCount++;
                lastHsCyc = cyc;
                chk("out_pending", expOutQ.size() != 0, 1);
                if (expOutQ.size() != 0) begin
                    e = expOutQ.pop_front();
                    chk("out_data", out_data, e[7:0]);
                    chk("out_last", out_last, e[8]);
                end
                if (out_last) lastCount++;
            end
            if (prevOV && !prevOR && !out_valid) protoErr++;
            if (RequestReadBuffer && out_valid) protoErr++;
            if (flip_pulse) begin
                flipCount++;
                flipCyc = cyc;
                expFlip = ~expFlip;
                expFrameCount = expFrameCount + 8'd1;
                chk("flip_sel", FlipBuffer, expFlip);
                chk("frame_count", frame_count, expFrameCount);
                chk("flip_wr_idle", RequestWriteBuffer, 0);
                chk("flip_rd_start", {RequestReadBuffer, BufferReadOffset}, {1'b1, 10'd0});
                if (prevPulse) protoErr++;
            end
            prevReq = RequestWriteBuffer;
            prevWD = BufferWriteData;
            prevWO = BufferWriteOffset;
            prevOV = out_valid;
            prevOR = out_ready;
            prevPulse = flip_pulse;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic sendByte(input logic [7:0] d, input logic sof,
                            output int lat, output logic [9:0] off, output logic [7:0] wd);
        int guard;
        guard = 0;
        while (!in_ready && guard < 5000) begin tick(); guard++; end
        if (!in_ready) chk("in_ready_timeout", in_ready, 1);
        in_valid = 1'b1;
        in_data = d;
        in_sof = sof;
        tick();
        in_valid = 1'b0;
        in_sof = 1'b0;
        off = BufferWriteOffset;
        wd = BufferWriteData;
        lat = 0;
        guard = 0;
        while (RequestWriteBuffer && guard < 5000) begin tick(); lat++; guard++; end
    endtask

    typedef struct {
        logic [7:0] data;
        logic       sof;
        int         stall;
        logic [9:0] expOff;
        int         expLat;
    } vec_t;
    vec_t vecs [8];

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : main
        int lat, guard, base;
        logic [9:0] off;
        logic [7:0] wd;

        vecs[0] = '{8'h00, 1'b0, 0,  10'd0, 4};
        vecs[1] = '{8'h01, 1'b0, 0,  10'd1, 4};
        vecs[2] = '{8'h02, 1'b0, 50, 10'd2, 54};
        vecs[3] = '{8'h03, 1'b0, 7,  10'd3, 11};
        vecs[4] = '{8'h00, 1'b1, 0,  10'd0, 4};
        vecs[5] = '{8'h01, 1'b0, 0,  10'd1, 4};
        vecs[6] = '{8'h02, 1'b0, 1,  10'd2, 5};
        vecs[7] = '{8'h03, 1'b0, 0,  10'd3, 4};

        // reset state
        #2 resetn = 1'b0;
        #3;
        chk("reset_outputs", {in_ready, RequestWriteBuffer, BufferWriteData, BufferWriteOffset,
                              RequestReadBuffer, BufferReadOffset, out_valid, out_data, out_last,
                              FlipBuffer, flip_pulse, frame_count}, 64'd0);
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("ready_after_reset", in_ready, 1);
        out_ready = 1'b1;

        // frame 1: table vectors (incl. 50-cycle stall and sof restart), then 4..255
        for (int i = 0; i < 8; i++) begin
            wrStall = vecs[i].stall;
            sendByte(vecs[i].data, vecs[i].sof, lat, off, wd);
            chk($sformatf("vec%0d_off", i), off, vecs[i].expOff);
            chk($sformatf("vec%0d_data", i), wd, vecs[i].data);
            chk($sformatf("vec%0d_lat", i), lat, vecs[i].expLat);
        end
        wrStall = 0;
        for (int i = 4; i < N; i++) begin
            sendByte(8'(i), 1'b0, lat, off, wd);
            chk("f1_off", off, i);
            if (i == 100) chk("f1_lat", lat, 4);
        end
        tick(); tick();
        chk("f1_flipsel", FlipBuffer, 1);
        chk("f1_frames", frame_count, 1);
        chk("f1_pulses", flipCount, 1);

        // drain frame 1 with consumer always ready
        guard = 0;
        while (hsCount < N && guard < 5000) begin tick(); guard++; end
        repeat (5) tick();
        chk("f1_drained", hsCount, N);
        chk("f1_last_once", lastCount, 1);
        chk("rd_idle", {RequestReadBuffer, out_valid}, 0);

        // frame 2: reader empty, flips as soon as it is full
        for (int i = 0; i < N; i++) sendByte(8'(255 - i), 1'b0, lat, off, wd);
        tick(); tick();
        chk("f2_frames", frame_count, 2);
        chk("f2_flipsel", FlipBuffer, 0);

        // stall the consumer after 10 bytes of frame 2
        guard = 0;
        while (hsCount < N + 10 && guard < 5000) begin tick(); guard++; end
        out_ready = 1'b0;
        chk("stall_reached", hsCount >= N + 10, 1);

        // frame 3: sof on the byte after offset 99, then 255 more bytes
        for (int i = 0; i < 100; i++) sendByte(8'(i + 7), 1'b0, lat, off, wd);
        sendByte(8'hC0, 1'b1, lat, off, wd);
        chk("sof_off", off, 0);
        for (int i = 1; i < N; i++) begin
            if (i == N - 1) chk("not_full_yet", in_ready, 1);
            sendByte(8'(i * 3), 1'b0, lat, off, wd);
            if (i == N - 1) chk("sof_last_off", off, N - 1);
        end
        repeat (100) tick();
        chk("full_no_flip", frame_count, 2);
        chk("full_in_ready", in_ready, 0);
        base = flipCount;
        out_ready = 1'b1;
        guard = 0;
        while (flipCount == base && guard < 5000) begin tick(); guard++; end
        tick();
        chk("stalled_flip", frame_count, 3);
        chk("flip_after_last_hs", flipCyc, lastHsCyc + 1);

        // randomized traffic with random controller stalls
        randStall = 1'b1;
        for (int c = 0; c < 12000; c++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            in_data = 8'($urandom);
            in_sof = ($urandom_range(0, 999) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        in_valid = 1'b0;
        in_sof = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((expOutQ.size() != 0 || out_valid || RequestReadBuffer || RequestWriteBuffer)
               && guard < 20000) begin tick(); guard++; end
        repeat (4) tick();
        chk("rand_out_drained", expOutQ.size(), 0);
        chk("rand_wr_drained", expWrQ.size(), 0);
        chk("rand_frames", flipCount >= 5, 1);
        randStall = 1'b0;

        // reset while both a read and a write are outstanding
        rdStall = 300;
        sendByte(8'h11, 1'b1, lat, off, wd);
        for (int i = 1; i < N; i++) sendByte(8'(i ^ 8'h5A), 1'b0, lat, off, wd);
        tick(); tick();
        wrStall = 300;
        in_valid = 1'b1;
        in_data = 8'h77;
        tick();
        in_valid = 1'b0;
        repeat (5) tick();
        chk("pre_reset_wr_req", RequestWriteBuffer, 1);
        chk("pre_reset_rd_req", RequestReadBuffer, 1);
        #2 resetn = 1'b0;
        #1;
        chk("midreset_outputs", {in_ready, RequestWriteBuffer, BufferWriteData, BufferWriteOffset,
                                 RequestReadBuffer, BufferReadOffset, out_valid, out_data, out_last,
                                 FlipBuffer, flip_pulse, frame_count}, 64'd0);
        wrStall = 0;
        rdStall = 0;
        tick(); tick();
        resetn = 1'b1;
        tick();
        chk("post_reset_ready", in_ready, 1);
        chk("post_reset_offs", {BufferWriteOffset, BufferReadOffset}, 0);
        sendByte(8'h5A, 1'b0, lat, off, wd);
        chk("post_reset_off", off, 0);
        chk("post_reset_data", wd, 8'h5A);
        chk("post_reset_lat", lat, 4);
        repeat (5) tick();
        chk("protocol_errors", protoErr, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
